main_mem_ctrl: RTL and testbench

- Backing-store controller that sits directly downstream of the set-associative cache controller.
- Serves whole-block requests from the cache: block fills (read) and dirty-victim write-backs (write).
- Holds the main-memory array. Moves one word per beat over valid/ready channels after a programmable access latency.
- Replaces the cache's built-in single-cycle block copy with a realistic multi-cycle handshake.

---
 rtl/main_mem_ctrl.sv | 138 +++++++++++++
 tb/tb_main_mem_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_ctrl.sv
// Main-memory controller behind the cache: serves whole-block fills and write-backs
// one word per beat over valid/ready channels after a fixed access latency.
module main_mem_ctrl #(
    parameter int DATA_WIDTH       = 32,
    parameter int WORDS_PER_BLOCK  = 16,
    parameter int BLOCK_ADDR_WIDTH = 12,
    parameter int ACCESS_LATENCY   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic                        i_req_write,
    input  logic [BLOCK_ADDR_WIDTH-1:0] i_req_block_addr,
    input  logic                        i_wdata_valid,
    output logic                        o_wdata_ready,
    input  logic [DATA_WIDTH-1:0]       i_wdata,
    output logic                        o_rdata_valid,
    input  logic                        i_rdata_ready,
    output logic [DATA_WIDTH-1:0]       o_rdata,
    output logic                        o_rdata_last,
    output logic                        o_resp_done,
    output logic                        o_busy
);

    localparam int BEAT_W = $clog2(WORDS_PER_BLOCK);
    localparam int MEM_AW = BLOCK_ADDR_WIDTH + BEAT_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [7:0] LAT_LOAD = 8'(ACCESS_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WR_BURST,
        S_RD_BURST,
        S_DONE
    } state_t;

    state_t                      r_state;
    state_t                      w_nextState;
    logic [7:0]                  r_latCnt;
    logic [BEAT_W-1:0]           r_beat;
    logic                        r_write;
    logic [BLOCK_ADDR_WIDTH-1:0] r_addr;

    logic [DATA_WIDTH-1:0] r_mem [2**MEM_AW];

    logic              w_reqFire;
    logic              w_wrFire;
    logic              w_rdFire;
    logic [MEM_AW-1:0] w_memIdx;

    assign w_reqFire = (r_state == S_IDLE) && i_req_valid;
    assign w_wrFire  = (r_state == S_WR_BURST) && i_wdata_valid;
    assign w_rdFire  = (r_state == S_RD_BURST) && i_rdata_ready;
    assign w_memIdx  = {r_addr, r_beat};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:     if (w_reqFire) w_nextState = S_WAIT;
            S_WAIT:     if (r_latCnt == 8'd0) w_nextState = r_write ? S_WR_BURST : S_RD_BURST;
            S_WR_BURST: if (w_wrFire && (r_beat == LAST_BEAT)) w_nextState = S_DONE;
            S_RD_BURST: if (w_rdFire && (r_beat == LAST_BEAT)) w_nextState = S_DONE;
            S_DONE:     w_nextState = S_IDLE;
            default:    w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready   = 1'b0;
        o_wdata_ready = 1'b0;
        o_rdata_valid = 1'b0;
        o_rdata_last  = 1'b0;
        o_resp_done   = 1'b0;
        o_busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                o_busy      = 1'b0;
            end
            S_WR_BURST: o_wdata_ready = 1'b1;
            S_RD_BURST: begin
                o_rdata_valid = 1'b1;
                o_rdata_last  = (r_beat == LAST_BEAT);
            end
            S_DONE:     o_resp_done = 1'b1;
            default: ;
        endcase
    end

    // Beat counter stops on the last beat so it never wraps inside a burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_latCnt <= 8'd0;
            r_beat   <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_reqFire) begin
                        r_write  <= i_req_write;
                        r_addr   <= i_req_block_addr;
                        r_latCnt <= LAT_LOAD;
                        r_beat   <= '0;
                    end
                end
                S_WAIT: begin
                    if (r_latCnt != 8'd0) r_latCnt <= r_latCnt - 8'd1;
                end
                S_WR_BURST: begin
                    if (w_wrFire && (r_beat != LAST_BEAT)) r_beat <= r_beat + 1'b1;
                end
                S_RD_BURST: begin
                    if (w_rdFire && (r_beat != LAST_BEAT)) r_beat <= r_beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Storage is deliberately unreset so partial write-backs survive a reset.
    always_ff @(posedge clk) begin
        if (w_wrFire) r_mem[w_memIdx] <= i_wdata;
    end

    assign o_rdata = r_mem[w_memIdx];

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Randomised scoreboard bench for main_mem_ctrl; fills are checked by a monitor
// against expectations drawn from a word-addressed reference memory.
module tb_main_mem_ctrl;

    localparam int DW  = 32;
    localparam int WPB = 16;
    localparam int BAW = 12;
    localparam int LAT = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           i_req_valid = 1'b0;
    logic           o_req_ready;
    logic           i_req_write = 1'b0;
    logic [BAW-1:0] i_req_block_addr = '0;
    logic           i_wdata_valid = 1'b0;
    logic           o_wdata_ready;
    logic [DW-1:0]  i_wdata = '0;
    logic           o_rdata_valid;
    logic           i_rdata_ready = 1'b0;
    logic [DW-1:0]  o_rdata;
    logic           o_rdata_last;
    logic           o_resp_done;
    logic           o_busy;

    int checkCnt = 0;
    int passCnt = 0;
    int popCount = 0;
    logic [DW-1:0] model [int];
    exp_t expQ[$];
    logic [BAW-1:0] written[$];

    main_mem_ctrl #(
        .DATA_WIDTH(DW),
        .WORDS_PER_BLOCK(WPB),
        .BLOCK_ADDR_WIDTH(BAW),
        .ACCESS_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_write(i_req_write),
        .i_req_block_addr(i_req_block_addr),
        .i_wdata_valid(i_wdata_valid),
        .o_wdata_ready(o_wdata_ready),
        .i_wdata(i_wdata),
        .o_rdata_valid(o_rdata_valid),
        .i_rdata_ready(i_rdata_ready),
        .o_rdata(o_rdata),
        .o_rdata_last(o_rdata_last),
        .o_resp_done(o_resp_done),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCnt++;
        if (actual === expected) passCnt++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    endtask

    function automatic int wordKey(input logic [BAW-1:0] addr, input int beat);
        return int'(addr) * WPB + beat;
    endfunction

    // Monitor: pops one expectation per fill handshake and watches hold-stability and completion.
    logic          prevStall = 1'b0;
    logic          prevLastHs = 1'b0;
    logic [DW-1:0] prevData = '0;
    logic          prevLast = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prevStall  = 1'b0;
            prevLastHs = 1'b0;
        end else begin
            if (prevLastHs) checkOutput("resp_done after last fill beat", {31'b0, o_resp_done}, 32'd1);
            if (prevStall) begin
                checkOutput("rdata_valid held", {31'b0, o_rdata_valid}, 32'd1);
                checkOutput("rdata held", o_rdata, prevData);
                checkOutput("rdata_last held", {31'b0, o_rdata_last}, {31'b0, prevLast});
            end
            prevLastHs = 1'b0;
            if (o_rdata_valid && i_rdata_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected fill beat", o_rdata, 32'hxxxxxxxx);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("fill data", o_rdata, e.data);
                    checkOutput("fill rdata_last", {31'b0, o_rdata_last}, {31'b0, e.last});
                    prevLastHs = e.last;
                end
                popCount++;
            end
            prevStall = o_rdata_valid && !i_rdata_ready;
            prevData  = o_rdata;
            prevLast  = o_rdata_last;
        end
    end

    task automatic issueReq(input logic wr, input logic [BAW-1:0] addr);
        int n;
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_write = wr;
        i_req_block_addr = addr;
        n = 0;
        while (!o_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("request accepted in time", {31'b0, o_req_ready}, 32'd1);
        @(posedge clk);
        #1 i_req_valid = 1'b0;
    endtask

    task automatic doWrite(input logic [BAW-1:0] addr, input logic [DW-1:0] base,
                           input int stallMode, input int abortAfter, input bit holdNext);
        int cnt;
        issueReq(1'b1, addr);
        if (holdNext) begin
            i_req_valid = 1'b1;
            i_req_write = 1'b0;
            i_req_block_addr = 12'h111;
        end
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (holdNext) checkOutput("req_ready low while waiting", {31'b0, o_req_ready}, 32'd0);
        end while (!o_wdata_ready && cnt < 50);
        checkOutput("first wdata_ready latency", cnt, LAT + 1);
        for (int i = 0; i < WPB; i++) begin
            int gap;
            gap = (stallMode == 1) ? (i % 2) : ((stallMode == 2) ? int'($urandom_range(0, 2)) : 0);
            if (gap > 0) begin
                i_wdata_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            i_wdata_valid = 1'b1;
            i_wdata = base + DW'(i);
            checkOutput("wdata_ready during burst", {31'b0, o_wdata_ready}, 32'd1);
            if (holdNext) checkOutput("req_ready low during burst", {31'b0, o_req_ready}, 32'd0);
            @(posedge clk);
            model[wordKey(addr, i)] = base + DW'(i);
            if (abortAfter == i + 1) begin
                #1 reset = 1'b1;
                i_wdata_valid = 1'b0;
                #1;
                checkOutput("abort: outputs at reset values",
                            {27'b0, o_req_ready, o_busy, o_wdata_ready, o_rdata_valid, o_resp_done},
                            32'b10000);
                repeat (2) @(posedge clk);
                #1 reset = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("abort: no resp_done", {31'b0, o_resp_done}, 32'd0);
                    checkOutput("abort: idle", {31'b0, o_busy}, 32'd0);
                end
                return;
            end
            @(negedge clk);
        end
        i_wdata_valid = 1'b0;
        checkOutput("write resp_done", {31'b0, o_resp_done}, 32'd1);
        checkOutput("req_ready low in done", {31'b0, o_req_ready}, 32'd0);
        @(negedge clk);
        checkOutput("resp_done single cycle", {31'b0, o_resp_done}, 32'd0);
        checkOutput("req_ready back after write", {31'b0, o_req_ready}, 32'd1);
        if (holdNext) begin
            @(posedge clk);
            #1 i_req_valid = 1'b0;
            @(negedge clk);
            checkOutput("held request accepted in first idle cycle", {31'b0, o_busy}, 32'd1);
        end
    endtask

    task automatic doRead(input logic [BAW-1:0] addr, input int mode, input bit skipReq);
        int target;
        int cyc;
        target = popCount + WPB;
        for (int i = 0; i < WPB; i++) begin
            exp_t e;
            e.data = model[wordKey(addr, i)];
            e.last = (i == WPB - 1);
            expQ.push_back(e);
        end
        if (!skipReq) issueReq(1'b0, addr);
        cyc = 0;
        while (popCount < target && cyc < 400) begin
            @(posedge clk);
            #1;
            case (mode)
                0:       i_rdata_ready = 1'b1;
                1:       i_rdata_ready = (cyc % 3 == 0);
                default: i_rdata_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
            @(negedge clk);
            #1;
        end
        checkOutput("fill completed in time", {31'b0, popCount >= target}, 32'd1);
        if (popCount < target) expQ.delete();
        @(posedge clk);
        #1 i_rdata_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("idle after fill", {31'b0, o_busy}, 32'd0);
    endtask

    task automatic applyStimulus();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("outputs during reset",
                    {27'b0, o_req_ready, o_busy, o_wdata_ready, o_rdata_valid, o_resp_done}, 32'b10000);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            checkOutput("idle outputs stable",
                        {27'b0, o_req_ready, o_busy, o_wdata_ready, o_rdata_valid, o_resp_done}, 32'b10000);
        end

        doWrite(12'h02A, 32'h0000_1000, 0, 0, 1'b0);
        doRead(12'h02A, 0, 1'b0);
        doRead(12'h02A, 1, 1'b0);
        doWrite(12'h02B, 32'h0000_1000, 1, 0, 1'b0);
        doRead(12'h02B, 0, 1'b0);

        doWrite(12'hFFF, 32'hDEAD_0000, 0, 0, 1'b0);
        doWrite(12'h000, 32'hBEEF_0000, 0, 0, 1'b0);
        doRead(12'hFFF, 0, 1'b0);
        doRead(12'h000, 2, 1'b0);

        doWrite(12'h111, 32'h1111_0000, 0, 0, 1'b0);
        doWrite(12'h02A, 32'h2000_0000, 0, 0, 1'b1);
        doRead(12'h111, 0, 1'b1);
        doRead(12'h02A, 2, 1'b0);

        doWrite(12'h055, 32'h7777_0000, 0, 0, 1'b0);
        doWrite(12'h055, 32'hAAAA_0000, 0, 6, 1'b0);
        doRead(12'h055, 0, 1'b0);
        doWrite(12'h055, 32'h5555_0000, 0, 0, 1'b0);
        doRead(12'h055, 1, 1'b0);

        written.push_back(12'h02A);
        written.push_back(12'hFFF);
        written.push_back(12'h000);
        for (int n = 0; n < 8; n++) begin
            logic [BAW-1:0] a;
            a = BAW'($urandom_range(0, 4095));
            doWrite(a, $urandom, 2, 0, 1'b0);
            written.push_back(a);
            doRead(a, 2, 1'b0);
            doRead(written[$urandom_range(0, written.size() - 1)], 2, 1'b0);
        end
    endtask

    initial begin
        $display("[TB] starting main_mem_ctrl bench");
        applyStimulus();
        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
